// File: rtl/fetch_stage.sv
// Instruction fetch stage: sequential PC, one-outstanding-request memory port,
// 2-entry {instr, pc} queue toward decode, and redirect-driven squash.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Rst_n,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemGnt,
    input  logic [31:0] IMemData,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    output logic [31:0] Instruction,
    output logic [31:0] InstrPC,
    output logic        InstrValid,
    input  logic        InstrReady
);

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    entry_t      q [2];
    logic        head;
    logic        tail;
    logic [1:0]  count;
    logic [31:0] pc;
    logic        in_flight;
    logic [31:0] in_flight_pc;
    logic        drop;

    logic        pop;
    logic        push;
    logic        accept;
    logic [2:0]  credit;

    always_comb begin
        InstrValid  = (count != 2'd0) & ~Redirect;
        pop         = InstrValid & InstrReady;
        push        = in_flight & ~drop & ~Redirect;
        // Words held or still arriving, minus the one leaving now; a new request
        // is only made when its data is guaranteed a free slot.
        credit      = {1'b0, count} + {2'b00, in_flight} - {2'b00, pop};
        // NOTE: gating with Rst_n keeps the request low while reset is held,
        // even though the credit check alone would already allow a fetch.
        IMemReq     = Rst_n & ~Redirect & (credit < 3'd2);
        accept      = IMemReq & IMemGnt;
        IMemAddr    = pc;
        Instruction = '0;
        InstrPC     = '0;
        if (count != 2'd0) begin
            Instruction = q[head].instr;
            InstrPC     = q[head].pc;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            pc           <= RESET_PC;
            in_flight    <= 1'b0;
            in_flight_pc <= '0;
            drop         <= 1'b0;
            head         <= 1'b0;
            tail         <= 1'b0;
            count        <= 2'd0;
        end else begin
            in_flight <= accept;
            drop      <= Redirect & in_flight;
            if (accept) begin
                in_flight_pc <= pc;
            end
            if (Redirect) begin
                pc    <= RedirectPC & ~32'd3;
                head  <= 1'b0;
                tail  <= 1'b0;
                count <= 2'd0;
            end else begin
                if (accept) begin
                    pc <= pc + 32'd4;
                end
                if (push) begin
                    tail <= ~tail;
                end
                if (pop) begin
                    head <= ~head;
                end
                count <= count + {1'b0, push} - {1'b0, pop};
            end
        end
    end

    // NOTE: queue storage is left unreset; count gates every read, so stale
    // contents are never observable.
    always_ff @(posedge Clk) begin
        if (push) begin
            q[tail] <= {IMemData, in_flight_pc};
        end
    end

endmodule
